multimode_waveform_generator: RTL and testbench



---
 rtl/multimode_waveform_generator_if.sv | 31 +++
 rtl/multimode_waveform_generator.sv | 173 +++++++++++++++++
 tb/tb_multimode_waveform_generator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/multimode_waveform_generator_if.sv
// rtl/multimode_waveform_generator_if.sv - sample, phase, config and output bundle for the waveform generator
//
// Signals:
//   s_axis_tdata / s_axis_tvalid              DDS sine sample and its valid
//   s_axis_tdata_phase / s_axis_tvalid_phase  DDS phase word and its valid
//   cfg_data                                  live configuration word
//   m_axis_tdata / m_axis_tvalid              shaped DAC sample and its valid
// Modports: master drives the inputs and observes the output; slave is the generator side.
interface multimode_waveform_generator_if #(
  parameter int AXIS_TDATA_WIDTH       = 16,
  parameter int AXIS_TDATA_PHASE_WIDTH = 16,
  parameter int CFG_DATA_WIDTH         = 64
);
  logic [AXIS_TDATA_WIDTH-1:0]       s_axis_tdata;
  logic                              s_axis_tvalid;
  logic [AXIS_TDATA_PHASE_WIDTH-1:0] s_axis_tdata_phase;
  logic                              s_axis_tvalid_phase;
  logic [CFG_DATA_WIDTH-1:0]         cfg_data;
  logic                              m_axis_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0]       m_axis_tdata;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tdata_phase, s_axis_tvalid_phase, cfg_data,
    input  m_axis_tvalid, m_axis_tdata
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tdata_phase, s_axis_tvalid_phase, cfg_data,
    output m_axis_tvalid, m_axis_tdata
  );
endinterface

// File: rtl/multimode_waveform_generator.sv
// rtl/multimode_waveform_generator.sv - six-shape waveform generator with gain, offset and DAC saturation
//
// Ports:
//   clk      sample clock
//   aresetn  asynchronous active-low reset, released synchronously
//   bus      slave view of the sample/phase/config inputs and the DAC output stream
// Pipeline: stage 1 captures sample and reduced phase, stage 2 forms the shape,
// stage 3 applies amplitude, stage 4 adds offset and saturates. Fixed latency of 4.
module multimode_waveform_generator #(
  parameter int AXIS_TDATA_WIDTH       = 16,
  parameter int AXIS_TDATA_PHASE_WIDTH = 16,
  parameter int DAC_WIDTH              = 14,
  parameter int CFG_DATA_WIDTH         = 64
) (
  input logic clk,
  input logic aresetn,
  multimode_waveform_generator_if.slave bus
);
  localparam int D  = DAC_WIDTH;
  localparam int TW = AXIS_TDATA_WIDTH;
  localparam int PW = AXIS_TDATA_PHASE_WIDTH;
  // Shape math is wide enough to hold a full triangle shifted left by the largest ramp shift.
  localparam int WS = D + 11;
  localparam int WP = D + 2;
  localparam int WA = ((D + 2) > 17 ? (D + 2) : 17) + 1;

  localparam logic signed [WS-1:0] FS_S   = WS'(2 ** (D - 1) - 1);
  localparam logic signed [WS-1:0] HALF_S = WS'(2 ** (D - 1));
  localparam logic signed [WS-1:0] H_S    = WS'(2 ** (D - 2));
  localparam logic signed [WA-1:0] FS_A   = WA'(2 ** (D - 1) - 1);

  // Active (shadowed) configuration
  logic [3:0]  mode_q, mode_d;
  logic        en_q, en_d;
  logic [2:0]  r_q, r_d;
  logic [15:0] amp_q, amp_d;
  logic [15:0] off_q, off_d;
  logic        msb_q, msb_d;
  logic [3:0]  vld_q, vld_d;

  // Pipeline registers
  logic signed [D-1:0]  sine1_q, sine1_d, p1_q, p1_d;
  logic signed [D-1:0]  shape2_q, shape2_d;
  logic [15:0]          amp2_q, amp2_d, off2_q, off2_d;
  logic signed [WP-1:0] prod3_q, prod3_d;
  logic [15:0]          off3_q, off3_d;
  logic signed [D-1:0]  out_q, out_d;

  logic                  in_valid, phase_msb, wrap;
  logic signed [WS-1:0]  p_s, tri_s, shape_s, shape_c;
  logic signed [D+16:0]  shape_x, amp_x, prod_full;
  logic signed [WA-1:0]  sum_a, sat_a;
  logic                  unused_bits;

  always_comb begin
    in_valid  = bus.s_axis_tvalid & bus.s_axis_tvalid_phase;
    phase_msb = bus.s_axis_tdata_phase[PW-1];
    // Period boundary: phase MSB rising between consecutive valid samples.
    wrap      = in_valid & ~msb_q & phase_msb;

    mode_d = mode_q;
    en_d   = en_q;
    r_d    = r_q;
    amp_d  = amp_q;
    off_d  = off_q;
    // While disabled the shadow tracks cfg_data so enabling is immediate.
    if (wrap || !en_q) begin
      mode_d = bus.cfg_data[3:0];
      en_d   = bus.cfg_data[4];
      r_d    = bus.cfg_data[7:5];
      amp_d  = bus.cfg_data[47:32];
      off_d  = bus.cfg_data[63:48];
    end
    msb_d = in_valid ? phase_msb : msb_q;
    vld_d = {vld_q[2:0], in_valid};

    // Stage 1: top D phase bits are the arithmetic shift of the phase word.
    sine1_d = in_valid ? bus.s_axis_tdata[D-1:0] : sine1_q;
    p1_d    = in_valid ? bus.s_axis_tdata_phase[PW-1 -: D] : p1_q;

    // Stage 2
    p_s = {{(WS - D){p1_q[D-1]}}, p1_q};
    if (p_s < -H_S) begin
      tri_s = -((p_s + HALF_S) <<< 1);
    end else if (p_s >= H_S) begin
      tri_s = (HALF_S - p_s) <<< 1;
    end else begin
      tri_s = p_s <<< 1;
    end
    case (mode_q)
      4'd0:    shape_s = {{(WS - D){sine1_q[D-1]}}, sine1_q};
      4'd1:    shape_s = tri_s <<< r_q;
      4'd2:    shape_s = tri_s;
      4'd3:    shape_s = p_s;
      4'd4:    shape_s = -p_s;
      4'd5:    shape_s = p_s[WS-1] ? -FS_S : FS_S;
      default: shape_s = '0;
    endcase
    if (!en_q) shape_s = '0;
    if (shape_s > FS_S) begin
      shape_c = FS_S;
    end else if (shape_s < -FS_S) begin
      shape_c = -FS_S;
    end else begin
      shape_c = shape_s;
    end
    // Amplitude and offset travel with the sample so a later reload cannot touch it.
    shape2_d = vld_q[0] ? shape_c[D-1:0] : shape2_q;
    amp2_d   = vld_q[0] ? amp_q : amp2_q;
    off2_d   = vld_q[0] ? off_q : off2_q;

    // Stage 3: slicing off 15 LSBs is the floor shift of the exact product.
    shape_x   = {{17{shape2_q[D-1]}}, shape2_q};
    amp_x     = {{(D + 1){1'b0}}, amp2_q};
    prod_full = shape_x * amp_x;
    prod3_d   = vld_q[1] ? prod_full[D+16:15] : prod3_q;
    off3_d    = vld_q[1] ? off2_q : off3_q;

    // Stage 4
    sum_a = {{(WA - WP){prod3_q[WP-1]}}, prod3_q} + {{(WA - 16){off3_q[15]}}, off3_q};
    if (sum_a > FS_A) begin
      sat_a = FS_A;
    end else if (sum_a < -FS_A) begin
      sat_a = -FS_A;
    end else begin
      sat_a = sum_a;
    end
    out_d = vld_q[2] ? sat_a[D-1:0] : out_q;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q   <= '0;
      en_q     <= 1'b0;
      r_q      <= '0;
      amp_q    <= '0;
      off_q    <= '0;
      msb_q    <= 1'b0;
      vld_q    <= '0;
      sine1_q  <= '0;
      p1_q     <= '0;
      shape2_q <= '0;
      amp2_q   <= '0;
      off2_q   <= '0;
      prod3_q  <= '0;
      off3_q   <= '0;
      out_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      en_q     <= en_d;
      r_q      <= r_d;
      amp_q    <= amp_d;
      off_q    <= off_d;
      msb_q    <= msb_d;
      vld_q    <= vld_d;
      sine1_q  <= sine1_d;
      p1_q     <= p1_d;
      shape2_q <= shape2_d;
      amp2_q   <= amp2_d;
      off2_q   <= off2_d;
      prod3_q  <= prod3_d;
      off3_q   <= off3_d;
      out_q    <= out_d;
    end
  end

  assign bus.m_axis_tvalid = vld_q[3];
  assign bus.m_axis_tdata  = {{(TW - D){out_q[D-1]}}, out_q};

  // Reserved config bits, discarded phase LSBs and sample sign-extension bits.
  assign unused_bits = ^{shape_c, sat_a, prod_full, bus.s_axis_tdata,
                         bus.s_axis_tdata_phase, bus.cfg_data};
endmodule

// File: tb/tb_multimode_waveform_generator.sv
// tb/tb_multimode_waveform_generator.sv - directed vector bench for multimode_waveform_generator
module tb_multimode_waveform_generator;
  logic clk = 1'b0;
  logic aresetn = 1'b1;
  always #4 clk = ~clk;

  multimode_waveform_generator_if #(
    .AXIS_TDATA_WIDTH(16), .AXIS_TDATA_PHASE_WIDTH(16), .CFG_DATA_WIDTH(64)
  ) bus_if ();

  multimode_waveform_generator #(
    .AXIS_TDATA_WIDTH(16), .AXIS_TDATA_PHASE_WIDTH(16), .DAC_WIDTH(14), .CFG_DATA_WIDTH(64)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .bus(bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [63:0] cfg;
    logic [15:0] sine;
    logic [15:0] phase;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] ph;
    logic        v;
    logic [63:0] cfg;
    logic [15:0] exp;
  } st_t;

  vec_t vecs[$];
  st_t  stq[$];

  function automatic logic [63:0] mk_cfg(input logic [3:0] mode, input logic en, input logic [2:0] r,
                                         input logic [15:0] amp, input logic [15:0] off);
    return {off, amp, 24'h0, r, en, mode};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [63:0] cfg, input logic [15:0] sine,
                         input logic [15:0] phase, input logic [15:0] exp);
    vec_t v;
    v.name = name; v.cfg = cfg; v.sine = sine; v.phase = phase; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic add_st(input logic [15:0] ph, input logic v, input logic [63:0] cfg, input logic [15:0] exp);
    st_t s;
    s.ph = ph; s.v = v; s.cfg = cfg; s.exp = exp;
    stq.push_back(s);
  endtask

  task automatic do_reset(input logic [63:0] cfg);
    @(posedge clk); #1;
    aresetn = 1'b0;
    bus_if.cfg_data = cfg;
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.s_axis_tvalid_phase = 1'b0;
    bus_if.s_axis_tdata = 16'h0;
    bus_if.s_axis_tdata_phase = 16'h0;
    @(posedge clk); #1;
    aresetn = 1'b1;
  endtask

  // One sample per cycle; sample k is checked 4 edges after it is driven.
  task automatic run_stream(input string name);
    int n;
    logic [15:0] held;
    n = stq.size();
    held = 16'h0;
    for (int k = 0; k < n + 4; k++) begin
      @(posedge clk); #1;
      if (k >= 4) begin
        check($sformatf("%s[%0d] tvalid", name, k - 4), {31'h0, bus_if.m_axis_tvalid}, {31'h0, stq[k-4].v});
        if (stq[k-4].v) held = stq[k-4].exp;
        check($sformatf("%s[%0d] tdata", name, k - 4), {16'h0, bus_if.m_axis_tdata}, {16'h0, held});
      end
      if (k < n) begin
        bus_if.cfg_data = stq[k].cfg;
        bus_if.s_axis_tdata_phase = stq[k].ph;
        bus_if.s_axis_tvalid = 1'b1;
        bus_if.s_axis_tvalid_phase = stq[k].v;
      end else begin
        bus_if.s_axis_tvalid_phase = 1'b0;
      end
    end
    stq.delete();
  endtask

  logic [63:0] c_saw, c_rsaw, c_sine;

  initial begin
    bus_if.cfg_data = 64'h0;
    bus_if.s_axis_tdata = 16'h0;
    bus_if.s_axis_tdata_phase = 16'h0;
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.s_axis_tvalid_phase = 1'b0;

    c_sine = mk_cfg(4'd0, 1'b1, 3'd0, 16'h8000, 16'h0000);
    c_saw  = mk_cfg(4'd3, 1'b1, 3'd0, 16'h8000, 16'h0000);
    c_rsaw = mk_cfg(4'd4, 1'b1, 3'd0, 16'h8000, 16'h0000);

    add_vec("sine_4096",    c_sine, 16'h1000, 16'h0000, 16'h1000);
    add_vec("tri_2000",     mk_cfg(4'd2, 1'b1, 3'd0, 16'h8000, 16'h0), 16'h0, 16'h2000, 16'h1000);
    add_vec("tri_4000",     mk_cfg(4'd2, 1'b1, 3'd0, 16'h8000, 16'h0), 16'h0, 16'h4000, 16'h1FFF);
    add_vec("tri_C000",     mk_cfg(4'd2, 1'b1, 3'd0, 16'h8000, 16'h0), 16'h0, 16'hC000, 16'hE001);
    add_vec("tri_E000",     mk_cfg(4'd2, 1'b1, 3'd0, 16'h8000, 16'h0), 16'h0, 16'hE000, 16'hF000);
    add_vec("trap_0800",    mk_cfg(4'd1, 1'b1, 3'd2, 16'h8000, 16'h0), 16'h0, 16'h0800, 16'h1000);
    add_vec("trap_2000",    mk_cfg(4'd1, 1'b1, 3'd2, 16'h8000, 16'h0), 16'h0, 16'h2000, 16'h1FFF);
    add_vec("trap_F800",    mk_cfg(4'd1, 1'b1, 3'd2, 16'h8000, 16'h0), 16'h0, 16'hF800, 16'hF000);
    add_vec("saw_off100",   mk_cfg(4'd3, 1'b1, 3'd0, 16'h8000, 16'd100), 16'h0, 16'h7FFC, 16'h1FFF);
    add_vec("saw_half_m100", mk_cfg(4'd3, 1'b1, 3'd0, 16'h4000, 16'hFF9C), 16'h0, 16'h7FFC, 16'h0F9B);
    add_vec("saw_max_neg",  mk_cfg(4'd3, 1'b1, 3'd0, 16'hFFFF, 16'h8000), 16'h0, 16'h7FFC, 16'hE001);
    add_vec("rsaw_min",     c_rsaw, 16'h0, 16'h8000, 16'h1FFF);
    add_vec("square_neg",   mk_cfg(4'd5, 1'b1, 3'd0, 16'h8000, 16'h0), 16'h0, 16'h8000, 16'hE001);
    add_vec("square_zero",  mk_cfg(4'd5, 1'b1, 3'd0, 16'h8000, 16'h0), 16'h0, 16'h0000, 16'h1FFF);
    add_vec("mode7_off5",   mk_cfg(4'd7, 1'b1, 3'd0, 16'h8000, 16'd5), 16'h0, 16'h2000, 16'h0005);
    add_vec("disabled_off7", mk_cfg(4'd3, 1'b0, 3'd0, 16'h8000, 16'd7), 16'h0, 16'h2000, 16'h0007);
    add_vec("sine_neg_half", mk_cfg(4'd0, 1'b1, 3'd0, 16'h4000, 16'h0), 16'hF000, 16'h0000, 16'hF800);
    add_vec("sine_low_bits", c_sine, 16'h7000, 16'h0000, 16'hF000);

    // Reset state, asserted with no clock edge in between.
    #1 aresetn = 1'b0;
    #1;
    check("reset tvalid", {31'h0, bus_if.m_axis_tvalid}, 32'h0);
    check("reset tdata", {16'h0, bus_if.m_axis_tdata}, 32'h0);

    // Single-sample latency.
    bus_if.cfg_data = c_sine;
    bus_if.s_axis_tdata = 16'h1000;
    @(posedge clk); #1 aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle tvalid", {31'h0, bus_if.m_axis_tvalid}, 32'h0);
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_tvalid_phase = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      bus_if.s_axis_tvalid = 1'b0;
      check($sformatf("latency edge%0d tvalid", e), {31'h0, bus_if.m_axis_tvalid}, (e == 4) ? 32'h1 : 32'h0);
      if (e >= 4) check($sformatf("latency edge%0d tdata", e), {16'h0, bus_if.m_axis_tdata}, 32'h1000);
    end

    foreach (vecs[i]) begin
      do_reset(vecs[i].cfg);
      bus_if.s_axis_tdata = vecs[i].sine;
      bus_if.s_axis_tdata_phase = vecs[i].phase;
      bus_if.s_axis_tvalid = 1'b1;
      bus_if.s_axis_tvalid_phase = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check({vecs[i].name, " tvalid"}, {31'h0, bus_if.m_axis_tvalid}, 32'h1);
      check({vecs[i].name, " tdata"}, {16'h0, bus_if.m_axis_tdata}, {16'h0, vecs[i].exp});
    end

    // Mode change mid-period only applies from the wrap.
    do_reset(c_saw);
    bus_if.s_axis_tdata = 16'h0;
    add_st(16'h0000, 1'b1, c_saw,  16'h0000);
    add_st(16'h1000, 1'b1, c_saw,  16'h0400);
    add_st(16'h2000, 1'b1, c_saw,  16'h0800);
    add_st(16'h3000, 1'b1, c_rsaw, 16'h0C00);
    add_st(16'h4000, 1'b1, c_rsaw, 16'h1000);
    add_st(16'h5000, 1'b1, c_rsaw, 16'h1400);
    add_st(16'h6000, 1'b1, c_rsaw, 16'h1800);
    add_st(16'h7000, 1'b1, c_rsaw, 16'h1C00);
    add_st(16'h7FFF, 1'b1, c_rsaw, 16'h1FFF);
    add_st(16'h8000, 1'b1, c_rsaw, 16'h1FFF);
    add_st(16'h9000, 1'b1, c_rsaw, 16'h1C00);
    add_st(16'hA000, 1'b1, c_rsaw, 16'h1800);
    run_stream("switch");

    // Three-cycle phase-valid gap spanning the wrap; wrap seen on the next valid sample.
    do_reset(c_saw);
    add_st(16'h6000, 1'b1, c_saw,  16'h1800);
    add_st(16'h7000, 1'b1, c_saw,  16'h1C00);
    add_st(16'h8000, 1'b0, c_rsaw, 16'h0000);
    add_st(16'h8800, 1'b0, c_rsaw, 16'h0000);
    add_st(16'h8800, 1'b0, c_rsaw, 16'h0000);
    add_st(16'h9000, 1'b1, c_rsaw, 16'h1C00);
    add_st(16'h9800, 1'b1, c_rsaw, 16'h1A00);
    add_st(16'h1000, 1'b1, c_rsaw, 16'hFC00);
    run_stream("gap");

    // Asynchronous reset mid-stream, then restart latency.
    do_reset(c_sine);
    bus_if.s_axis_tdata = 16'h1000;
    bus_if.s_axis_tdata_phase = 16'h0000;
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_tvalid_phase = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("prereset tvalid", {31'h0, bus_if.m_axis_tvalid}, 32'h1);
    #2 aresetn = 1'b0;
    #1;
    check("async reset tvalid", {31'h0, bus_if.m_axis_tvalid}, 32'h0);
    check("async reset tdata", {16'h0, bus_if.m_axis_tdata}, 32'h0);
    @(posedge clk); #1 aresetn = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      check($sformatf("restart edge%0d tvalid", e), {31'h0, bus_if.m_axis_tvalid}, (e == 4) ? 32'h1 : 32'h0);
      check($sformatf("restart edge%0d tdata", e), {16'h0, bus_if.m_axis_tdata}, (e == 4) ? 32'h1000 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
